// File: rtl/alu_issue_if.sv
`default_nettype none
// ============================================================================
// alu_issue_if : request/result valid-ready bundle for alu_issue_stage
// Rev 1.0
// ============================================================================
interface alu_issue_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [OP_WIDTH-1:0]   in_op;
  logic [DATA_WIDTH-1:0] in_a;
  logic [DATA_WIDTH-1:0] in_b;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_r;
  logic [OP_WIDTH-1:0]   out_op;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_r, out_op
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_r, out_op
  );
endinterface
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// alu_issue_stage : request FIFO feeding an external ALU, registered result slot
// Rev 1.0
// ============================================================================
module alu_issue_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  alu_issue_if.slave                 bus,
  output logic [OP_WIDTH-1:0]        alu_op,
  output logic [DATA_WIDTH-1:0]      alu_a,
  output logic [DATA_WIDTH-1:0]      alu_b,
  input  logic [DATA_WIDTH-1:0]      alu_r,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [OP_WIDTH-1:0]   mem_op [DEPTH];
  logic [DATA_WIDTH-1:0] mem_a  [DEPTH];
  logic [DATA_WIDTH-1:0] mem_b  [DEPTH];

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  head_valid;
  logic                  in_ready;
  logic                  push;
  logic                  load;
  logic                  res_valid;
  logic [DATA_WIDTH-1:0] res_r;
  logic [OP_WIDTH-1:0]   res_op;

  // in_ready looks only at the pre-pop occupancy, so a full FIFO never takes a push
  assign head_valid = (count != '0);
  assign in_ready   = (count != CNT_W'(DEPTH));
  assign push       = bus.in_valid & in_ready & ~flush;
  assign load       = head_valid & (~res_valid | bus.out_ready) & ~flush;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = res_valid;
  assign bus.out_r     = res_r;
  assign bus.out_op    = res_op;

  always_comb begin
    alu_op = '0;
    alu_a  = '0;
    alu_b  = '0;
    if (head_valid) begin
      alu_op = mem_op[rd_ptr];
      alu_a  = mem_a[rd_ptr];
      alu_b  = mem_b[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_op[wr_ptr] <= bus.in_op;
      mem_a[wr_ptr]  <= bus.in_a;
      mem_b[wr_ptr]  <= bus.in_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (load) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !load)      count <= count + CNT_W'(1);
      else if (!push && load) count <= count - CNT_W'(1);
    end
  end

  // flush drops the slot's valid but keeps the last result visible
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_r     <= '0;
      res_op    <= '0;
    end else if (flush) begin
      res_valid <= 1'b0;
    end else if (load) begin
      res_valid <= 1'b1;
      res_r     <= alu_r;
      res_op    <= alu_op;
    end else if (res_valid && bus.out_ready) begin
      res_valid <= 1'b0;
    end
  end
endmodule
`default_nettype wire
